// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the keypad calculator core.
//   Key codes delivered by the keypad scanner (0-15 are hex digits),
//   the pending-operation encoding shown on the op output, and the
//   control FSM state encoding.
package calc_pkg;

  localparam logic [4:0] KEY_EQ  = 5'd16;
  localparam logic [4:0] KEY_BS  = 5'd17;
  localparam logic [4:0] KEY_ADD = 5'd18;
  localparam logic [4:0] KEY_SUB = 5'd19;
  localparam logic [4:0] KEY_MUL = 5'd20;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2
  } op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } calc_state_t;

endpackage

// File: rtl/calc_if.sv
// calc_if: key-event input and display-side outputs of the calculator core.
//   key_valid  one-cycle pulse, key_code valid this cycle
//   key_code   0-15 digit, 16 '=', 17 backspace, 18 '+', 19 '-', 20 '*'
//   value      display value (accumulator when showing a result, else entry)
//   dig_en     per-digit display enable with leading-zero blanking
//   op         pending operation (0 add, 1 sub, 2 mul)
//   busy       multiply in progress
//   ovf        overflow/borrow from the last completed result
// The master modport is the keypad side, the slave modport is the core.
interface calc_if #(
  parameter int DIGITS = 8
);

  logic                  key_valid;
  logic [4:0]            key_code;
  logic [4*DIGITS-1:0]   value;
  logic [DIGITS-1:0]     dig_en;
  logic [1:0]            op;
  logic                  busy;
  logic                  ovf;

  modport master (
    output key_valid, key_code,
    input  value, dig_en, op, busy, ovf
  );

  modport slave (
    input  key_valid, key_code,
    output value, dig_en, op, busy, ovf
  );

endinterface

// File: rtl/calc_mul.sv
// calc_mul: sequential shift-add multiplier, one multiplier bit per cycle.
//   hz100  clock
//   reset  asynchronous active-high reset, aborts any multiply in flight
//   start  load a/b and begin; ignored while busy
//   a, b   operands (DW bits)
//   busy   high for exactly DW cycles after the start edge
//   done   high during the last busy cycle; p holds the full product then
//   p      product (2*DW bits), meaningful while done is high
module calc_mul #(
  parameter int DW = 32
) (
  input  logic            hz100,
  input  logic            reset,
  input  logic            start,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  output logic            busy,
  output logic            done,
  output logic [2*DW-1:0] p
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  logic            busy_q, busy_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*DW-1:0] mcand_q, mcand_d;
  logic [DW-1:0]   mplier_q, mplier_d;
  logic [2*DW-1:0] prod_q, prod_d;
  logic [2*DW-1:0] sum;

  // The final partial product is folded in combinationally so the full
  // product is available during the last busy cycle, letting the caller
  // capture it on the same edge that busy drops.
  assign sum  = prod_q + (mplier_q[0] ? mcand_q : '0);
  assign p    = sum;
  assign busy = busy_q;
  assign done = busy_q && (cnt_q == LAST);

  // Next-state: load on start, otherwise shift one multiplier bit per cycle.
  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    if (busy_q) begin
      prod_d   = sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (cnt_q == LAST) begin
        busy_d = 1'b0;
      end
    end else if (start) begin
      busy_d   = 1'b1;
      cnt_d    = '0;
      mcand_d  = {{DW{1'b0}}, a};
      mplier_d = b;
      prod_d   = '0;
    end
  end

  always_ff @(posedge hz100 or posedge reset) begin
    if (reset) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
    end
  end

endmodule

// File: rtl/calc_engine.sv
// calc_engine: keypad calculator core.
//   hz100   system clock
//   reset   asynchronous active-high reset
//   bus     calc_if slave: key events in, display value / digit enables /
//           pending op / busy / overflow out
// Digits build a hex operand with backspace and leading-zero tracking;
// '+', '-', '*' latch the entry into the accumulator; '=' applies the
// pending operation (multiply takes DW cycles, keys are dropped meanwhile).
module calc_engine
  import calc_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic hz100,
  input  logic reset,
  calc_if.slave bus
);

  localparam int DW = 4 * DIGITS;
  localparam int NW = $clog2(DIGITS + 1);
  localparam logic [NW-1:0] DIGITS_N = NW'(DIGITS);

  logic [DW-1:0] cur_q, cur_d;
  logic [DW-1:0] acc_q, acc_d;
  op_t           op_q, op_d;
  logic          show_q, show_d;
  logic [NW-1:0] ndig_q, ndig_d;
  logic          ovf_q, ovf_d;
  calc_state_t   state_q, state_d;

  logic            mulStart;
  logic            mulDone;
  logic [2*DW-1:0] mulP;
  logic [DW:0]     addSum;
  logic [3:0]      digit;

  assign addSum = {1'b0, acc_q} + {1'b0, cur_q};
  assign digit  = bus.key_code[3:0];

  // The multiplier only exists when multiply is enabled; otherwise the
  // done/product inputs are tied off and OP_MUL can never become pending.
  generate
    if (MUL_EN) begin : gen_mul
      logic mulBusy;
      calc_mul #(.DW(DW)) u_mul (
        .hz100 (hz100),
        .reset (reset),
        .start (mulStart),
        .a     (acc_q),
        .b     (cur_q),
        .busy  (mulBusy),
        .done  (mulDone),
        .p     (mulP)
      );
    end else begin : gen_nomul
      assign mulDone = 1'b0;
      assign mulP    = '0;
    end
  endgenerate

  // Key decode and FSM next-state. In ST_MUL every key event is dropped and
  // only the multiplier completion is acted on.
  always_comb begin
    cur_d    = cur_q;
    acc_d    = acc_q;
    op_d     = op_q;
    show_d   = show_q;
    ndig_d   = ndig_q;
    ovf_d    = ovf_q;
    state_d  = state_q;
    mulStart = 1'b0;
    if (state_q == ST_MUL) begin
      if (mulDone) begin
        acc_d   = mulP[DW-1:0];
        ovf_d   = |mulP[2*DW-1:DW];
        show_d  = 1'b1;
        state_d = ST_IDLE;
      end
    end else if (bus.key_valid) begin
      if (!bus.key_code[4]) begin
        // A digit while a result is shown starts a fresh entry; leading
        // zeros do not count toward the digit limit.
        if (show_q) begin
          cur_d  = DW'(digit);
          ndig_d = NW'(digit != 4'd0);
          show_d = 1'b0;
        end else if (ndig_q < DIGITS_N) begin
          cur_d = {cur_q[DW-5:0], digit};
          if (!(ndig_q == '0 && digit == 4'd0)) begin
            ndig_d = ndig_q + NW'(1);
          end
        end
      end else begin
        case (bus.key_code)
          KEY_BS: begin
            if (!show_q && ndig_q != '0) begin
              cur_d  = cur_q >> 4;
              ndig_d = ndig_q - NW'(1);
            end
          end
          KEY_ADD, KEY_SUB, KEY_MUL: begin
            if (bus.key_code != KEY_MUL || MUL_EN) begin
              // With a result already shown the accumulator is kept, so a
              // second operator key just replaces the pending operation.
              if (!show_q) begin
                acc_d = cur_q;
              end
              op_d   = (bus.key_code == KEY_ADD) ? OP_ADD :
                       (bus.key_code == KEY_SUB) ? OP_SUB : OP_MUL;
              cur_d  = '0;
              ndig_d = '0;
              show_d = 1'b1;
              ovf_d  = 1'b0;
            end
          end
          KEY_EQ: begin
            // cur is retained so repeated '=' repeats the operation.
            case (op_q)
              OP_ADD: begin
                acc_d  = addSum[DW-1:0];
                ovf_d  = addSum[DW];
                show_d = 1'b1;
              end
              OP_SUB: begin
                acc_d  = acc_q - cur_q;
                ovf_d  = (acc_q < cur_q);
                show_d = 1'b1;
              end
              default: begin
                mulStart = 1'b1;
                state_d  = ST_MUL;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge hz100 or posedge reset) begin
    if (reset) begin
      cur_q   <= '0;
      acc_q   <= '0;
      op_q    <= OP_ADD;
      show_q  <= 1'b0;
      ndig_q  <= '0;
      ovf_q   <= 1'b0;
      state_q <= ST_IDLE;
    end else begin
      cur_q   <= cur_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
      show_q  <= show_d;
      ndig_q  <= ndig_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
    end
  end

  assign bus.value = show_q ? acc_q : cur_q;
  assign bus.op    = op_q;
  assign bus.busy  = (state_q == ST_MUL);
  assign bus.ovf   = ovf_q;

  // Leading-zero blanking: digit i lights if any digit at or above it is
  // non-zero; the least significant digit is always lit.
  assign bus.dig_en[0] = 1'b1;
  generate
    for (genvar i = 1; i < DIGITS; i++) begin : gen_digen
      assign bus.dig_en[i] = |bus.value[DW-1:4*i];
    end
  endgenerate

endmodule

// File: tb/tb_calc_engine.sv
// tb_calc_engine: directed, table-driven bench for calc_engine (DIGITS=8).
module tb_calc_engine;

  logic hz100;
  logic reset;
  int   checks;
  int   fails;

  calc_if #(.DIGITS(8)) bus ();

  calc_engine #(.DIGITS(8), .MUL_EN(1'b1)) dut (
    .hz100 (hz100),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    hz100 = 1'b0;
    forever #5 hz100 = ~hz100;
  end

  typedef struct {
    logic        rst;
    logic [4:0]  code;
    logic [31:0] expValue;
    logic [7:0]  expDigEn;
    logic [1:0]  expOp;
    logic        expOvf;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic rst, input logic [4:0] code,
                        input logic [31:0] v, input logic [7:0] de,
                        input logic [1:0] op, input logic ovf);
    vec_t t;
    t.rst = rst; t.code = code; t.expValue = v;
    t.expDigEn = de; t.expOp = op; t.expOvf = ovf;
    vecs.push_back(t);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    @(posedge hz100);
    #1;
    reset = 1'b0;
    @(posedge hz100);
    #1;
  endtask

  task automatic pressKey(input logic [4:0] code);
    bus.key_valid = 1'b1;
    bus.key_code  = code;
    @(posedge hz100);
    #1;
    bus.key_valid = 1'b0;
    bus.key_code  = 5'd0;
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.rst) doReset();
    else       pressKey(v.code);
  endtask

  // Counts sampled cycles with busy high; optionally pulses a key mid-busy.
  task automatic waitBusy(output int cycles, input int injectAt,
                          input logic [4:0] injectCode);
    int guard;
    cycles = 0;
    guard  = 0;
    while (bus.busy && guard < 200) begin
      cycles++;
      if (cycles == injectAt) begin
        bus.key_valid = 1'b1;
        bus.key_code  = injectCode;
      end
      @(posedge hz100);
      #1;
      bus.key_valid = 1'b0;
      bus.key_code  = 5'd0;
      guard++;
    end
  endtask

  initial begin
    int busyCycles;
    checks = 0;
    fails  = 0;
    reset  = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_code  = 5'd0;
    #12;

    // Entry, leading zeros, digit limit, backspace.
    addVec(1, 0,      32'h0,        8'h01, 0, 0);
    addVec(0, 1,      32'h1,        8'h01, 0, 0);
    addVec(0, 2,      32'h12,       8'h03, 0, 0);
    addVec(0, 3,      32'h123,      8'h07, 0, 0);
    addVec(1, 0,      32'h0,        8'h01, 0, 0);
    addVec(0, 0,      32'h0,        8'h01, 0, 0);
    addVec(0, 0,      32'h0,        8'h01, 0, 0);
    addVec(0, 1,      32'h1,        8'h01, 0, 0);
    addVec(0, 2,      32'h12,       8'h03, 0, 0);
    addVec(0, 3,      32'h123,      8'h07, 0, 0);
    addVec(0, 4,      32'h1234,     8'h0F, 0, 0);
    addVec(0, 5,      32'h12345,    8'h1F, 0, 0);
    addVec(0, 6,      32'h123456,   8'h3F, 0, 0);
    addVec(0, 7,      32'h1234567,  8'h7F, 0, 0);
    addVec(0, 8,      32'h12345678, 8'hFF, 0, 0);
    addVec(0, 9,      32'h12345678, 8'hFF, 0, 0);
    addVec(0, 17,     32'h01234567, 8'h7F, 0, 0);
    addVec(0, 9,      32'h12345679, 8'hFF, 0, 0);
    addVec(0, 9,      32'h12345679, 8'hFF, 0, 0);
    // Add, repeated '=', new entry after result.
    addVec(1, 0,      32'h0,        8'h01, 0, 0);
    addVec(0, 17,     32'h0,        8'h01, 0, 0);
    addVec(0, 5,      32'h5,        8'h01, 0, 0);
    addVec(0, 18,     32'h5,        8'h01, 0, 0);
    addVec(0, 3,      32'h3,        8'h01, 0, 0);
    addVec(0, 16,     32'h8,        8'h01, 0, 0);
    addVec(0, 16,     32'hB,        8'h01, 0, 0);
    addVec(0, 7,      32'h7,        8'h01, 0, 0);
    // Subtract with borrow, operator replacement while showing a result.
    addVec(1, 0,      32'h0,        8'h01, 0, 0);
    addVec(0, 3,      32'h3,        8'h01, 0, 0);
    addVec(0, 19,     32'h3,        8'h01, 1, 0);
    addVec(0, 5,      32'h5,        8'h01, 1, 0);
    addVec(0, 16,     32'hFFFFFFFE, 8'hFF, 1, 1);
    addVec(0, 18,     32'hFFFFFFFE, 8'hFF, 0, 0);
    // Add carry-out, backspace and unused code ignored while showing.
    addVec(1, 0,      32'h0,        8'h01, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      logic [31:0] ones;
      logic [7:0]  en;
      ones = (32'h1 << (4 * k)) - 32'h1;
      if (k == 8) ones = 32'hFFFFFFFF;
      en = (8'h1 << k) - 8'h1;
      if (k == 8) en = 8'hFF;
      addVec(0, 15, ones, en, 0, 0);
    end
    addVec(0, 18,     32'hFFFFFFFF, 8'hFF, 0, 0);
    addVec(0, 1,      32'h1,        8'h01, 0, 0);
    addVec(0, 16,     32'h0,        8'h01, 0, 1);
    addVec(0, 17,     32'h0,        8'h01, 0, 1);
    addVec(0, 25,     32'h0,        8'h01, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d value", i), bus.value, vecs[i].expValue);
      checkOutput($sformatf("vec%0d dig_en", i), {24'h0, bus.dig_en}, {24'h0, vecs[i].expDigEn});
      checkOutput($sformatf("vec%0d op", i), {30'h0, bus.op}, {30'h0, vecs[i].expOp});
      checkOutput($sformatf("vec%0d ovf", i), {31'h0, bus.ovf}, {31'h0, vecs[i].expOvf});
    end

    // Multiply 0x1234 * 0x10 with a digit key dropped mid-busy.
    doReset();
    pressKey(1); pressKey(2); pressKey(3); pressKey(4);
    pressKey(20);
    checkOutput("mul op", {30'h0, bus.op}, 32'h2);
    pressKey(1); pressKey(0);
    pressKey(16);
    checkOutput("mul busy after eq", {31'h0, bus.busy}, 32'h1);
    waitBusy(busyCycles, 5, 5'd7);
    checkOutput("mul busy cycles", busyCycles, 32);
    checkOutput("mul busy end", {31'h0, bus.busy}, 32'h0);
    checkOutput("mul value", bus.value, 32'h00012340);
    checkOutput("mul ovf", {31'h0, bus.ovf}, 32'h0);

    // Multiply overflow: 0x10000 * 0x10000.
    doReset();
    pressKey(1); pressKey(0); pressKey(0); pressKey(0); pressKey(0);
    pressKey(20);
    pressKey(1); pressKey(0); pressKey(0); pressKey(0); pressKey(0);
    pressKey(16);
    waitBusy(busyCycles, 0, 5'd0);
    checkOutput("mulovf cycles", busyCycles, 32);
    checkOutput("mulovf value", bus.value, 32'h0);
    checkOutput("mulovf ovf", {31'h0, bus.ovf}, 32'h1);

    // Reset in the middle of a multiply, then a clean multiply.
    doReset();
    repeat (8) pressKey(15);
    pressKey(20);
    pressKey(2);
    pressKey(16);
    repeat (9) begin
      @(posedge hz100);
      #1;
    end
    checkOutput("abort busy before", {31'h0, bus.busy}, 32'h1);
    reset = 1'b1;
    #1;
    checkOutput("abort busy", {31'h0, bus.busy}, 32'h0);
    checkOutput("abort value", bus.value, 32'h0);
    checkOutput("abort dig_en", {24'h0, bus.dig_en}, 32'h1);
    checkOutput("abort op", {30'h0, bus.op}, 32'h0);
    @(posedge hz100);
    #1;
    reset = 1'b0;
    @(posedge hz100);
    #1;
    pressKey(2); pressKey(20); pressKey(3); pressKey(16);
    waitBusy(busyCycles, 0, 5'd0);
    checkOutput("post-abort cycles", busyCycles, 32);
    checkOutput("post-abort value", bus.value, 32'h6);
    checkOutput("post-abort ovf", {31'h0, bus.ovf}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
